// File: rtl/core_sequence_ctrl.sv
// core_sequence_ctrl: runs the cores selected in a mask one at a time.
// All tiles and cores are held in reset until the program image is resident.
// Each selected core is then released in index order, and its first rising
// pass or fail edge (or a timeout) is recorded in sticky result vectors.
// State table:
//   state     | meaning
//   IDLE      | block does not interfere; all resets released
//   WAIT_LOAD | tiles and cores held in reset until program_loaded_i
//   SELECT    | pick the next masked core at or above r_idx
//   PULSE     | virtual mode: all tile resets asserted for ALL_RST_CYCLES
//   RUN       | selected core out of reset; waiting for pass/fail/timeout
//   DONE      | sequence finished; cores held in reset, results kept
module core_sequence_ctrl #(
   parameter int NUM_CORES      = 4,
   parameter int ALL_RST_CYCLES = 2,
   parameter int TIMEOUT_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [NUM_CORES-1:0] core_mask_i,
   input  logic                 virtual_mode_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   input  logic                 program_loaded_i,
   input  logic [NUM_CORES-1:0] pass_i,
   input  logic [NUM_CORES-1:0] fail_i,
   output logic [NUM_CORES-1:0] tile_reset_o,
   output logic [NUM_CORES-1:0] core_reset_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [3:0]           cur_core_o,
   output logic [NUM_CORES-1:0] res_pass_o,
   output logic [NUM_CORES-1:0] res_fail_o,
   output logic [NUM_CORES-1:0] res_tmo_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_LOAD = 3'd1;
   localparam logic [2:0] S_SELECT    = 3'd2;
   localparam logic [2:0] S_PULSE     = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam logic [NUM_CORES-1:0] ALL_ONES = '1;

   logic [2:0]           r_state;
   logic [NUM_CORES-1:0] r_mask;
   logic                 r_vmode;
   logic [TIMEOUT_W-1:0] r_tmo;
   logic [TIMEOUT_W-1:0] r_cnt;
   // one bit wider than an index so it can step past the last core
   logic [4:0]           r_idx;
   logic                 r_prev_pass;
   logic                 r_prev_fail;
   logic                 r_done;
   logic [NUM_CORES-1:0] r_res_pass;
   logic [NUM_CORES-1:0] r_res_fail;
   logic [NUM_CORES-1:0] r_res_tmo;

   logic                 w_found;
   logic [4:0]           w_sel;
   logic                 w_sel_pass;
   logic                 w_sel_fail;
   logic                 w_cur_pass;
   logic                 w_cur_fail;
   logic [NUM_CORES-1:0] w_onehot;
   logic                 w_pass_evt;
   logic                 w_fail_evt;
   logic                 w_tmo_hit;
   logic                 w_start_ok;

   // Lowest masked core at or above r_idx, plus the status of the running core
   always_comb begin
      w_found    = 1'b0;
      w_sel      = '0;
      w_sel_pass = 1'b0;
      w_sel_fail = 1'b0;
      w_cur_pass = 1'b0;
      w_cur_fail = 1'b0;
      w_onehot   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (r_mask[i] && (i >= int'(r_idx))) begin
            w_found    = 1'b1;
            w_sel      = 5'(i);
            w_sel_pass = pass_i[i];
            w_sel_fail = fail_i[i];
         end
         if (int'(r_idx) == i) begin
            w_cur_pass  = pass_i[i];
            w_cur_fail  = fail_i[i];
            w_onehot[i] = 1'b1;
         end
      end
   end

   assign w_fail_evt = w_cur_fail & ~r_prev_fail;
   assign w_pass_evt = w_cur_pass & ~r_prev_pass;
   assign w_tmo_hit  = (r_tmo != '0) && (r_cnt == r_tmo - TIMEOUT_W'(1));
   assign w_start_ok = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

   // Reset nets decoded from the state; only RUN releases a single core
   always_comb begin
      tile_reset_o = '0;
      core_reset_o = ALL_ONES;
      case (r_state)
         S_IDLE:      core_reset_o = '0;
         S_WAIT_LOAD: tile_reset_o = ALL_ONES;
         S_PULSE:     tile_reset_o = ALL_ONES;
         S_RUN:       core_reset_o = ~w_onehot;
         default:     ;
      endcase
   end

   assign busy_o     = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done_o     = r_done;
   assign cur_core_o = r_idx[3:0];
   assign res_pass_o = r_res_pass;
   assign res_fail_o = r_res_fail;
   assign res_tmo_o  = r_res_tmo;

   // Sequencer state, counters and sticky results
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mask      <= '0;
         r_vmode     <= 1'b0;
         r_tmo       <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_prev_pass <= 1'b0;
         r_prev_fail <= 1'b0;
         r_done      <= 1'b0;
         r_res_pass  <= '0;
         r_res_fail  <= '0;
         r_res_tmo   <= '0;
      end else begin
         r_done <= 1'b0;
         if (abort_i) begin
            r_state <= S_IDLE;
         end else if (w_start_ok) begin
            r_mask     <= core_mask_i;
            r_vmode    <= virtual_mode_i;
            r_tmo      <= timeout_i;
            r_res_pass <= '0;
            r_res_fail <= '0;
            r_res_tmo  <= '0;
            r_state    <= S_WAIT_LOAD;
         end else begin
            case (r_state)
               S_WAIT_LOAD: begin
                  if (program_loaded_i) begin
                     r_idx   <= '0;
                     r_state <= S_SELECT;
                  end
               end
               S_SELECT: begin
                  if (!w_found) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_idx       <= w_sel;
                     r_cnt       <= '0;
                     r_prev_pass <= w_sel_pass;
                     r_prev_fail <= w_sel_fail;
                     r_state     <= r_vmode ? S_PULSE : S_RUN;
                  end
               end
               S_PULSE: begin
                  if (r_cnt == TIMEOUT_W'(ALL_RST_CYCLES - 1)) begin
                     r_cnt   <= '0;
                     r_state <= S_RUN;
                  end else begin
                     r_cnt <= r_cnt + TIMEOUT_W'(1);
                  end
               end
               S_RUN: begin
                  r_prev_pass <= w_cur_pass;
                  r_prev_fail <= w_cur_fail;
                  if (r_cnt != '1) r_cnt <= r_cnt + TIMEOUT_W'(1);
                  if (w_fail_evt || w_pass_evt || w_tmo_hit) begin
                     if (w_fail_evt)      r_res_fail <= r_res_fail | w_onehot;
                     else if (w_pass_evt) r_res_pass <= r_res_pass | w_onehot;
                     else                 r_res_tmo  <= r_res_tmo  | w_onehot;
                     r_idx   <= r_idx + 5'd1;
                     r_state <= S_SELECT;
                  end
               end
               S_IDLE, S_DONE: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_core_sequence_ctrl.sv
// Directed bench for core_sequence_ctrl (4 cores, 2-cycle tile pulse).
module tb_core_sequence_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, abort_i, virtual_mode_i, program_loaded_i;
   logic [3:0]  core_mask_i, pass_i, fail_i;
   logic [31:0] timeout_i;
   logic [3:0]  tile_reset_o, core_reset_o, cur_core_o;
   logic [3:0]  res_pass_o, res_fail_o, res_tmo_o;
   logic        busy_o, done_o;

   int n_tests = 0;
   int n_fail  = 0;

   core_sequence_ctrl #(.NUM_CORES(4), .ALL_RST_CYCLES(2), .TIMEOUT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .core_mask_i(core_mask_i), .virtual_mode_i(virtual_mode_i),
      .timeout_i(timeout_i), .program_loaded_i(program_loaded_i),
      .pass_i(pass_i), .fail_i(fail_i), .tile_reset_o(tile_reset_o),
      .core_reset_o(core_reset_o), .busy_o(busy_o), .done_o(done_o),
      .cur_core_o(cur_core_o), .res_pass_o(res_pass_o),
      .res_fail_o(res_fail_o), .res_tmo_o(res_tmo_o));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_seq(input logic [3:0] m, input logic v, input logic [31:0] t);
      core_mask_i    = m;
      virtual_mode_i = v;
      timeout_i      = t;
      start_i        = 1'b1;
      step();
      start_i        = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_tests++;
      if ({tile_reset_o, core_reset_o, busy_o, done_o, cur_core_o} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got tile=%b core=%b busy=%b done=%b cur=%0d exp all 0",
                  tile_reset_o, core_reset_o, busy_o, done_o, cur_core_o);
      end
      n_tests++;
      if ({res_pass_o, res_fail_o, res_tmo_o} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_results got %b %b %b exp 0", res_pass_o, res_fail_o, res_tmo_o);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_two_core_pass();
      start_seq(4'b0101, 1'b0, 32'd0);
      n_tests++;
      if (tile_reset_o !== 4'b1111 || core_reset_o !== 4'b1111 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL t1_wait_load got tile=%b core=%b busy=%b exp 1111 1111 1",
                  tile_reset_o, core_reset_o, busy_o);
      end
      repeat (10) step();
      program_loaded_i = 1'b1;
      step();
      step();
      n_tests++;
      if (core_reset_o !== 4'b1110 || tile_reset_o !== 4'b0000 || cur_core_o !== 4'd0) begin
         n_fail++;
         $display("FAIL t1_run0 got core=%b tile=%b cur=%0d exp 1110 0000 0",
                  core_reset_o, tile_reset_o, cur_core_o);
      end
      repeat (20) step();
      n_tests++;
      if (core_reset_o !== 4'b1110) begin
         n_fail++;
         $display("FAIL t1_run0_hold got core=%b exp 1110", core_reset_o);
      end
      pass_i[0] = 1'b1;
      step();
      n_tests++;
      if (core_reset_o !== 4'b1111) begin
         n_fail++;
         $display("FAIL t1_reassert got core=%b exp 1111", core_reset_o);
      end
      step();
      n_tests++;
      if (core_reset_o !== 4'b1011 || cur_core_o !== 4'd2) begin
         n_fail++;
         $display("FAIL t1_run2 got core=%b cur=%0d exp 1011 2", core_reset_o, cur_core_o);
      end
      repeat (30) step();
      pass_i[2] = 1'b1;
      step();
      step();
      n_tests++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || res_pass_o !== 4'b0101 ||
          res_fail_o !== 4'b0000 || res_tmo_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL t1_done got done=%b busy=%b pass=%b fail=%b tmo=%b exp 1 0 0101 0000 0000",
                  done_o, busy_o, res_pass_o, res_fail_o, res_tmo_o);
      end
      step();
      n_tests++;
      if (done_o !== 1'b0 || core_reset_o !== 4'b1111 || tile_reset_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL t1_done_hold got done=%b core=%b tile=%b exp 0 1111 0000",
                  done_o, core_reset_o, tile_reset_o);
      end
      pass_i = 4'b0000;
      program_loaded_i = 1'b0;
   endtask

   task automatic test_virtual_mode();
      logic [3:0] exp_core;
      int         pulse;
      start_seq(4'b1111, 1'b1, 32'd0);
      program_loaded_i = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         pulse = 0;
         for (int c = 0; c < 10; c++) begin
            step();
            if (tile_reset_o === 4'b1111) pulse++;
            else break;
         end
         exp_core = 4'b1111 ^ (4'b0001 << k);
         n_tests++;
         if (pulse != 2) begin
            n_fail++;
            $display("FAIL t2_pulse_len core %0d got %0d cycles exp 2", k, pulse);
         end
         n_tests++;
         if (core_reset_o !== exp_core || cur_core_o !== 4'(k)) begin
            n_fail++;
            $display("FAIL t2_run core %0d got core=%b cur=%0d exp %b %0d",
                     k, core_reset_o, cur_core_o, exp_core, k);
         end
         pass_i[k] = 1'b1;
         step();
      end
      step();
      n_tests++;
      if (done_o !== 1'b1 || res_pass_o !== 4'b1111) begin
         n_fail++;
         $display("FAIL t2_done got done=%b pass=%b exp 1 1111", done_o, res_pass_o);
      end
      pass_i = 4'b0000;
      program_loaded_i = 1'b0;
   endtask

   task automatic test_timeout();
      int low;
      start_seq(4'b0010, 1'b0, 32'd100);
      program_loaded_i = 1'b1;
      step();
      step();
      low = 0;
      for (int c = 0; c < 200; c++) begin
         if (core_reset_o[1] === 1'b0) low++;
         else break;
         step();
      end
      n_tests++;
      if (low != 100) begin
         n_fail++;
         $display("FAIL t3_timeout_len got %0d cycles exp 100", low);
      end
      n_tests++;
      if (res_tmo_o !== 4'b0010 || res_pass_o !== 4'b0000 || res_fail_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL t3_result got tmo=%b pass=%b fail=%b exp 0010 0000 0000",
                  res_tmo_o, res_pass_o, res_fail_o);
      end
      step();
      n_tests++;
      if (done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL t3_done got %b exp 1", done_o);
      end
      program_loaded_i = 1'b0;
   endtask

   task automatic test_priority();
      pass_i = 4'b0001;
      start_seq(4'b1001, 1'b0, 32'd0);
      program_loaded_i = 1'b1;
      step();
      step();
      repeat (5) step();
      n_tests++;
      if (core_reset_o !== 4'b1110 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL t4_level_ignored got core=%b busy=%b exp 1110 1", core_reset_o, busy_o);
      end
      pass_i[0] = 1'b0;
      step();
      pass_i[0] = 1'b1;
      step();
      step();
      n_tests++;
      if (core_reset_o !== 4'b0111 || cur_core_o !== 4'd3 || res_pass_o !== 4'b0001) begin
         n_fail++;
         $display("FAIL t4_run3 got core=%b cur=%0d pass=%b exp 0111 3 0001",
                  core_reset_o, cur_core_o, res_pass_o);
      end
      pass_i[3] = 1'b1;
      fail_i[3] = 1'b1;
      step();
      step();
      n_tests++;
      if (done_o !== 1'b1 || res_fail_o !== 4'b1000 || res_pass_o !== 4'b0001 ||
          res_tmo_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL t4_fail_priority got done=%b fail=%b pass=%b tmo=%b exp 1 1000 0001 0000",
                  done_o, res_fail_o, res_pass_o, res_tmo_o);
      end
      pass_i = 4'b0000;
      fail_i = 4'b0000;
      program_loaded_i = 1'b0;
   endtask

   task automatic test_mask_zero();
      int  cyc;
      logic low_seen;
      start_seq(4'b0000, 1'b0, 32'd0);
      program_loaded_i = 1'b1;
      cyc = 0;
      low_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         cyc++;
         if (core_reset_o !== 4'b1111) low_seen = 1'b1;
         if (done_o === 1'b1) break;
      end
      n_tests++;
      if (cyc != 2 || done_o !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_done_latency got %0d cycles done=%b exp 2 1", cyc, done_o);
      end
      n_tests++;
      if (low_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_core_reset_low got low_seen=%b exp 0", low_seen);
      end
      program_loaded_i = 1'b0;
   endtask

   task automatic test_abort_and_reset();
      start_seq(4'b0001, 1'b0, 32'd0);
      program_loaded_i = 1'b1;
      step();
      step();
      core_mask_i = 4'b1000;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      n_tests++;
      if (core_reset_o !== 4'b1110 || busy_o !== 1'b1 || cur_core_o !== 4'd0) begin
         n_fail++;
         $display("FAIL t6_start_ignored got core=%b busy=%b cur=%0d exp 1110 1 0",
                  core_reset_o, busy_o, cur_core_o);
      end
      abort_i = 1'b1;
      start_i = 1'b1;
      step();
      abort_i = 1'b0;
      start_i = 1'b0;
      n_tests++;
      if (tile_reset_o !== 4'b0000 || core_reset_o !== 4'b0000 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL t6_abort got tile=%b core=%b busy=%b exp 0000 0000 0",
                  tile_reset_o, core_reset_o, busy_o);
      end
      start_seq(4'b0001, 1'b1, 32'd0);
      step();
      step();
      n_tests++;
      if (tile_reset_o !== 4'b1111 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL t6_pulse got tile=%b busy=%b exp 1111 1", tile_reset_o, busy_o);
      end
      rst_n = 1'b0;
      step();
      n_tests++;
      if ({tile_reset_o, core_reset_o, busy_o, done_o, cur_core_o,
           res_pass_o, res_fail_o, res_tmo_o} !== 26'd0) begin
         n_fail++;
         $display("FAIL t6_reset_mid_pulse got tile=%b core=%b busy=%b done=%b cur=%0d exp all 0",
                  tile_reset_o, core_reset_o, busy_o, done_o, cur_core_o);
      end
      rst_n = 1'b1;
      program_loaded_i = 1'b0;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      start_i = 1'b0;
      abort_i = 1'b0;
      virtual_mode_i = 1'b0;
      program_loaded_i = 1'b0;
      core_mask_i = 4'b0000;
      pass_i = 4'b0000;
      fail_i = 4'b0000;
      timeout_i = 32'd0;
      test_reset();
      test_two_core_pass();
      test_virtual_mode();
      test_timeout();
      test_priority();
      test_mask_zero();
      test_abort_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
